// File: rtl/rx_dma_pkg.sv
// Shared RX DMA definitions: page-allocator FSM encoding, qword sizing and
// the request-size legality helper used by the huge-page allocator.
package rx_dma_pkg;

    typedef enum logic [1:0] {
        WAIT_P1 = 2'd0,
        USE_P1  = 2'd1,
        WAIT_P2 = 2'd2,
        USE_P2  = 2'd3
    } page_state_e;

    localparam int QW_BYTES           = 8;
    localparam int MAX_CHUNK_QW       = 256;
    localparam int CHUNK_QW_W         = $clog2(MAX_CHUNK_QW) + 1;
    localparam int DEFAULT_PAGE_BYTES = 2097152;

    // A chunk must be between one qword and MAX_CHUNK_QW qwords.
    function automatic logic chunk_qw_legal(input logic [CHUNK_QW_W-1:0] qw);
        return (qw != {CHUNK_QW_W{1'b0}}) && (qw <= CHUNK_QW_W'(MAX_CHUNK_QW));
    endfunction

endpackage

// File: rtl/rx_huge_page_alloc_if.sv
// Chunk request/grant handshake between the RX DMA TLP writer (master)
// and the huge-page allocator (slave).
interface rx_huge_page_alloc_if;
    import rx_dma_pkg::*;

    logic                  chunk_req;
    logic [CHUNK_QW_W-1:0] chunk_qwords;
    logic                  chunk_gnt;
    logic [63:0]           chunk_addr;
    logic                  page_flush;

    modport master (
        output chunk_req,
        output chunk_qwords,
        output page_flush,
        input  chunk_gnt,
        input  chunk_addr
    );

    modport slave (
        input  chunk_req,
        input  chunk_qwords,
        input  page_flush,
        output chunk_gnt,
        output chunk_addr
    );

endinterface

// File: rtl/rx_huge_page_alloc_fit_check.sv
// Combinational fit test for the next chunk: checks offset+need against the
// page size and produces the advanced offset.
module huge_page_fit_check
    import rx_dma_pkg::*;
#(
    parameter int PAGE_BYTES = DEFAULT_PAGE_BYTES,
    parameter int OFF_W      = $clog2(PAGE_BYTES) + 1
) (
    input  logic [OFF_W-1:0]      offset_i,
    input  logic [CHUNK_QW_W-1:0] qwords_i,
    output logic                  legal_o,
    output logic                  fits_o,
    output logic [OFF_W-1:0]      next_offset_o
);

    // One spare bit so an overshooting sum cannot wrap and look like a fit.
    localparam int SUM_W = OFF_W + 1;

    logic [SUM_W-1:0] need_s;
    logic [SUM_W-1:0] sum_s;

    // Size legality, byte count, fit compare and next offset.
    always_comb begin
        need_s        = SUM_W'(qwords_i) * SUM_W'(QW_BYTES);
        sum_s         = SUM_W'(offset_i) + need_s;
        legal_o       = chunk_qw_legal(qwords_i);
        fits_o        = legal_o && (sum_s <= SUM_W'(PAGE_BYTES));
        next_offset_o = sum_s[OFF_W-1:0];
    end

endmodule

// File: rtl/rx_huge_page_alloc.sv
// Ping-pong allocator over the two driver-announced huge pages: carves out
// contiguous chunks for the RX DMA writer and frees each page when closed.
module rx_huge_page_alloc
    import rx_dma_pkg::*;
#(
    parameter int PAGE_BYTES = DEFAULT_PAGE_BYTES,
    parameter int OFF_W      = $clog2(PAGE_BYTES) + 1
) (
    input  logic                    trn_clk,
    input  logic                    reset,
    input  logic [63:0]             huge_page_addr_1,
    input  logic [63:0]             huge_page_addr_2,
    input  logic                    huge_page_status_1,
    input  logic                    huge_page_status_2,
    output logic                    huge_page_free_1,
    output logic                    huge_page_free_2,
    rx_huge_page_alloc_if.slave     chunk_if,
    output logic [OFF_W-1:0]        page_used_bytes
);

    page_state_e      state_q;
    page_state_e      state_d;
    logic [63:0]      base_q;
    logic [63:0]      base_d;
    logic [OFF_W-1:0] offset_q;
    logic [OFF_W-1:0] offset_d;
    logic             chunk_gnt_q;
    logic             chunk_gnt_d;
    logic [63:0]      chunk_addr_q;
    logic [63:0]      chunk_addr_d;
    logic             free_1_q;
    logic             free_1_d;
    logic             free_2_q;
    logic             free_2_d;
    logic [OFF_W-1:0] used_q;
    logic [OFF_W-1:0] used_d;

    logic             legal_s;
    logic             fits_s;
    logic [OFF_W-1:0] next_offset_s;
    logic             in_use_s;
    logic             req_live_s;
    logic             grant_s;
    logic             close_s;
    logic             latch_s;

    huge_page_fit_check #(
        .PAGE_BYTES (PAGE_BYTES),
        .OFF_W      (OFF_W)
    ) u_fit_check (
        .offset_i      (offset_q),
        .qwords_i      (chunk_if.chunk_qwords),
        .legal_o       (legal_s),
        .fits_o        (fits_s),
        .next_offset_o (next_offset_s)
    );

    // Decision terms shared by the next-state and output processes.
    always_comb begin
        in_use_s   = (state_q == USE_P1) || (state_q == USE_P2);
        // The grant cycle itself never re-samples the request.
        req_live_s = chunk_if.chunk_req && !chunk_gnt_q && legal_s;
        grant_s    = in_use_s && req_live_s && fits_s;
        // A fitting request beats a coincident flush; the flush pulse is lost.
        close_s    = in_use_s &&
                     ((req_live_s && !fits_s) ||
                      (!req_live_s && chunk_if.page_flush &&
                       (offset_q != {OFF_W{1'b0}})));
        latch_s    = ((state_q == WAIT_P1) && huge_page_status_1) ||
                     ((state_q == WAIT_P2) && huge_page_status_2);
    end

    // Next-state logic of the page ping-pong FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_P1: state_d = huge_page_status_1 ? USE_P1 : WAIT_P1;
            USE_P1:  state_d = close_s ? WAIT_P2 : USE_P1;
            WAIT_P2: state_d = huge_page_status_2 ? USE_P2 : WAIT_P2;
            USE_P2:  state_d = close_s ? WAIT_P1 : USE_P2;
            default: state_d = WAIT_P1;
        endcase
    end

    // Datapath and output next values: base latch, grants, frees.
    always_comb begin
        base_d       = base_q;
        offset_d     = offset_q;
        chunk_gnt_d  = 1'b0;
        chunk_addr_d = chunk_addr_q;
        free_1_d     = 1'b0;
        free_2_d     = 1'b0;
        used_d       = used_q;

        if (latch_s) begin
            offset_d = {OFF_W{1'b0}};
            case (state_q)
                WAIT_P1: base_d = huge_page_addr_1;
                WAIT_P2: base_d = huge_page_addr_2;
                default: base_d = base_q;
            endcase
        end else if (grant_s) begin
            chunk_gnt_d  = 1'b1;
            chunk_addr_d = base_q + 64'(offset_q);
            offset_d     = next_offset_s;
        end else if (close_s) begin
            free_1_d = (state_q == USE_P1);
            free_2_d = (state_q == USE_P2);
            used_d   = offset_q;
        end else begin
            offset_d = offset_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            state_q      <= WAIT_P1;
            base_q       <= 64'd0;
            offset_q     <= {OFF_W{1'b0}};
            chunk_gnt_q  <= 1'b0;
            chunk_addr_q <= 64'd0;
            free_1_q     <= 1'b0;
            free_2_q     <= 1'b0;
            used_q       <= {OFF_W{1'b0}};
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            offset_q     <= offset_d;
            chunk_gnt_q  <= chunk_gnt_d;
            chunk_addr_q <= chunk_addr_d;
            free_1_q     <= free_1_d;
            free_2_q     <= free_2_d;
            used_q       <= used_d;
        end
    end

    assign chunk_if.chunk_gnt  = chunk_gnt_q;
    assign chunk_if.chunk_addr = chunk_addr_q;
    assign huge_page_free_1    = free_1_q;
    assign huge_page_free_2    = free_2_q;
    assign page_used_bytes     = used_q;

endmodule
